// File: rtl/sweep_angle_gen.sv
// Stepped angle sweep generator for the ultrasound scanner servo.
// Walks the commanded angle from ANGLE_MIN up to ANGLE_MAX and back down,
// dwelling PRESCALE cycles per angle, optionally waiting for the ranging
// front end to acknowledge each measurement before moving on.
module sweep_angle_gen #(
  parameter int ANGLE_W   = 8,
  parameter int ANGLE_MIN = 0,
  parameter int ANGLE_MAX = 180,
  parameter int STEP      = 1,
  parameter int PRESCALE  = 50000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic               wait_ack_en,
  input  logic               meas_ack,
  output logic [ANGLE_W-1:0] angle,
  output logic               direction,
  output logic               angle_valid,
  output logic               busy,
  output logic               sweep_done
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PRESCALE - 1);

  // One extra bit of headroom so that stepping past either limit can be
  // detected and saturated instead of wrapping around.
  localparam logic [ANGLE_W:0] MIN_X  = (ANGLE_W + 1)'(ANGLE_MIN);
  localparam logic [ANGLE_W:0] MAX_X  = (ANGLE_W + 1)'(ANGLE_MAX);
  localparam logic [ANGLE_W:0] STEP_X = (ANGLE_W + 1)'(STEP);

  typedef enum logic [1:0] {
    IDLE,
    DWELL,
    WAIT_ACK
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ANGLE_W-1:0] angle_q;
  logic               dir_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;

  logic [ANGLE_W:0]   angle_ext;
  logic [ANGLE_W:0]   up_sum;
  logic [ANGLE_W:0]   up_angle;
  logic [ANGLE_W:0]   down_angle;
  logic [ANGLE_W:0]   wrap_sum;
  logic [ANGLE_W:0]   wrap_angle;
  logic [ANGLE_W:0]   step_angle_d;
  logic               step_dir_d;
  logic               step_end_d;
  logic               take_step;

  // Saturating up/down candidates and the angle/direction a step would produce.
  always_comb begin
    angle_ext  = {1'b0, angle_q};
    up_sum     = angle_ext + STEP_X;
    up_angle   = (up_sum > MAX_X) ? MAX_X : up_sum;
    down_angle = (angle_ext >= (MIN_X + STEP_X)) ? (angle_ext - STEP_X) : MIN_X;
    wrap_sum   = MIN_X + STEP_X;
    wrap_angle = (wrap_sum > MAX_X) ? MAX_X : wrap_sum;

    step_angle_d = angle_ext;
    step_dir_d   = dir_q;
    step_end_d   = 1'b0;
    if (!dir_q) begin
      if (angle_ext < MAX_X) begin
        step_angle_d = up_angle;
      end else begin
        step_dir_d   = 1'b1;
        step_angle_d = down_angle;
      end
    end else begin
      if (angle_ext > MIN_X) begin
        step_angle_d = down_angle;
      end else begin
        step_end_d   = 1'b1;
        step_dir_d   = 1'b0;
        step_angle_d = wrap_angle;
      end
    end
  end

  // A step happens at the end of a dwell (no handshake) or when the ack arrives.
  always_comb begin
    take_step = ((state_q == DWELL) && (cnt_q == LAST_CNT) && !wait_ack_en) ||
                ((state_q == WAIT_ACK) && meas_ack);
  end

  // Sweep state machine with registered outputs; reset, then stop, then start win.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      angle_q <= ANGLE_W'(MIN_X);
      dir_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      if (stop) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        cnt_q   <= '0;
      end else if (start) begin
        state_q <= DWELL;
        cnt_q   <= '0;
        angle_q <= ANGLE_W'(MIN_X);
        dir_q   <= 1'b0;
        valid_q <= 1'b1;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          DWELL: begin
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= wait_ack_en ? WAIT_ACK : DWELL;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: begin
          end
        endcase
        if (take_step) begin
          if (step_end_d && !mode) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q <= DWELL;
            angle_q <= ANGLE_W'(step_angle_d);
            dir_q   <= step_dir_d;
            valid_q <= 1'b1;
            done_q  <= step_end_d;
          end
        end
      end
    end
  end

  assign angle       = angle_q;
  assign direction   = dir_q;
  assign angle_valid = valid_q;
  assign busy        = busy_q;
  assign sweep_done  = done_q;

endmodule
